imem_fetch_arbiter: RTL and testbench
=====================================

Name: imem_fetch_arbiter

Overview:
- Owns the single-port instruction RAM and shares it between the core fetch port and a NoC-side program loader.
- Sequences boot:
  - holds the core while a program image is streamed in;
  - releases the core;
  - then arbitrates live patch writes against fetches with a starvation guard.
- Sits between the IF stage (PC_F) and the imem_ram storage instance.

Parameters:
- ADDR_W, 4, word-address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32, instruction width.
- STARVE_LIM, 4, consecutive denied loader cycles in RUN before the loader is forced a grant.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- fetch_req  in  1  core requests instruction at fetch_pc
- fetch_pc  in  32  byte PC; word index = fetch_pc[ADDR_W+1:2]
- fetch_gnt  out  1  fetch accepted this cycle (combinational)
- fetch_valid  out  1  fetch_instr valid (registered)
- fetch_instr  out  DATA_W  fetched instruction
- ld_valid  in  1  loader write present
- ld_addr  in  ADDR_W  loader word address
- ld_data  in  DATA_W  loader write data
- ld_last  in  1  final word of boot image (meaningful in BOOT/LOAD only)
- ld_ready  out  1  loader write accepted when ld_valid & ld_ready
- core_hold  out  1  stall to core/PC logic
- load_count  out  ADDR_W+1  words written by the most recent boot load
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after the read address

Behaviour:
- FSM states: BOOT, LOAD, RUN. On rst (any cycle, including mid-load or with a fetch in flight), the FSM enters BOOT.
- Reset values:
  - core_hold=1
  - fetch_gnt=0, fetch_valid=0, fetch_instr=0
  - ld_ready=0 for the reset cycle
  - load_count=0, starvation counter=0
  - RAM contents are not cleared.
- BOOT:
  - ld_ready=1, core_hold=1, fetch_gnt=0.
  - An accepted write transitions to LOAD, or directly to RUN if ld_last=1.
  - load_count is set to 1.
- LOAD:
  - ld_ready=1, core_hold=1.
  - Each accepted write drives mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data, and increments load_count (saturates at DEPTH).
  - An accepted write with ld_last=1 transitions to RUN the next cycle.
  - Gaps with ld_valid=0 are legal and hold state.
- RUN:
  - core_hold=0. One RAM operation per cycle.
  - Default priority goes to fetch: fetch_gnt = fetch_req & ~force_ld.
  - ld_ready = ~fetch_req | force_ld.
  - force_ld = (starve_cnt == STARVE_LIM).
  - starve_cnt increments on each cycle with ld_valid & fetch_req & ~force_ld, and clears on any accepted loader write or on ld_valid=0.
  - When a loader write wins while fetch_req=1, fetch_gnt=0 and the core must hold fetch_req/fetch_pc.
  - ld_last is ignored in RUN.
- Fetch read path:
  - Granted fetch drives mem_addr = word index, mem_we=0.
  - Next cycle: fetch_valid=1 and fetch_instr=mem_rdata.
  - If fetch_pc[31:ADDR_W+2] != 0 (out of range), the RAM is not accessed and fetch_instr=0 (NOP) with fetch_valid=1 next cycle.
  - Latency is exactly 1 cycle; back-to-back grants give back-to-back valids.
- Read-after-write:
  - A write at cycle N followed by a fetch of the same address at N+1 returns the new data at N+2.
  - Writes and reads never coincide in the same cycle.
- Idle cycles: mem_we=0 and mem_addr holds its last value. fetch_valid falls the cycle after a cycle without a grant; fetch_instr holds.

Decomposition:
- Package imem_pkg:
  - state enum {BOOT, LOAD, RUN};
  - ADDR_W/DATA_W defaults;
  - NOP encoding constant (32'h0).
- Sub-module imem_ram:
  - DEPTH x DATA_W;
  - synchronous write;
  - registered read (1-cycle), no reset on the array.
- The arbiter FSM and starvation counter stay in imem_fetch_arbiter.

Test Plan:
- Boot: rst 2 cycles, then stream words 0..11 (word 11 with ld_last) → core_hold=1 throughout, load_count=12, RUN and core_hold=0 the cycle after the last accept; fetches of PC 0x0..0x2C return the loaded words one cycle after each grant.
- Fetch out of range: fetch_pc=0x40 (ADDR_W=4) → fetch_valid=1 next cycle, fetch_instr=0, mem_we=0 and no RAM read issued.
- Starvation guard: in RUN, hold fetch_req=1 continuously with ld_valid=1 → ld_ready=0 for 4 cycles, ld_ready=1 and fetch_gnt=0 on cycle 5, counter cleared, then fetch resumes.
- Patch then read: RUN, write addr 6 = 0xC1290041 with fetch_req=0, then fetch PC 0x18 → fetch_instr=0xC1290041 two cycles after the write.
- Reset mid-load: rst during LOAD after 5 words → BOOT next cycle, core_hold=1, load_count=0; a fresh 3-word load then reaches RUN with load_count=3 and the earlier words still readable.
- Gaps in load: ld_valid toggling 1,0,0,1(last) in LOAD → stays in LOAD during the gaps, load_count increments only on accepts, then RUN.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory fetch/loader arbiter.
package imem_pkg;

    localparam int ADDR_W_DEF     = 4;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_LIM_DEF = 4;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/imem_ram.sv
// Single-port instruction RAM: synchronous write, registered one-cycle read.
module imem_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Array is deliberately not reset so a boot image survives a core reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares the instruction RAM between the core fetch port and the NoC program
// loader: holds the core during boot load, then arbitrates with a starvation guard.
module imem_fetch_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              core_hold,
    output logic [ADDR_W:0]   load_count,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    state_t            r_state;
    logic              r_core_hold;
    logic [ADDR_W:0]   r_load_count;
    logic [CNT_W-1:0]  r_starve;
    logic              r_fetch_valid;
    logic              r_oob;
    logic [DATA_W-1:0] r_instr_hold;
    logic [ADDR_W-1:0] r_last_addr;

    logic              w_run;
    logic              w_force_ld;
    logic              w_ld_acc;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_word_idx;
    logic              w_unused_pc;

    assign w_run       = (r_state == RUN);
    assign w_force_ld  = w_run && (r_starve == CNT_W'(STARVE_LIM));
    assign w_in_range  = (fetch_pc[31:ADDR_W+2] == '0);
    assign w_word_idx  = fetch_pc[ADDR_W+1:2];
    assign w_unused_pc = ^fetch_pc[1:0];

    assign fetch_gnt = !rst && w_run && fetch_req && !w_force_ld;
    assign ld_ready  = !rst && (!w_run || !fetch_req || w_force_ld);
    assign w_ld_acc  = ld_valid && ld_ready;

    assign mem_we     = w_ld_acc;
    assign mem_wdata  = ld_data;
    assign core_hold  = r_core_hold;
    assign load_count = r_load_count;

    // Out-of-range fetches never touch the RAM, so the address bus keeps its last value.
    always_comb begin
        mem_addr = r_last_addr;
        if (w_ld_acc) begin
            mem_addr = ld_addr;
        end else if (fetch_gnt && w_in_range) begin
            mem_addr = w_word_idx;
        end
    end

    assign fetch_instr = r_fetch_valid ? (r_oob ? DATA_W'(NOP) : mem_rdata) : r_instr_hold;
    assign fetch_valid = r_fetch_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= BOOT;
            r_core_hold  <= 1'b1;
            r_load_count <= '0;
            r_starve     <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_starve <= '0;
                    if (w_ld_acc) begin
                        r_load_count <= (ADDR_W+1)'(1);
                        if (ld_last) begin
                            r_state     <= RUN;
                            r_core_hold <= 1'b0;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    r_starve <= '0;
                    if (w_ld_acc) begin
                        if (r_load_count != (ADDR_W+1)'(DEPTH)) begin
                            r_load_count <= r_load_count + (ADDR_W+1)'(1);
                        end
                        if (ld_last) begin
                            r_state     <= RUN;
                            r_core_hold <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // A denied loader write only counts while it is actually waiting.
                    if (w_ld_acc || !ld_valid) begin
                        r_starve <= '0;
                    end else if (fetch_req && !w_force_ld) begin
                        r_starve <= r_starve + CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= BOOT;
                    r_core_hold <= 1'b1;
                    r_starve    <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_valid <= 1'b0;
            r_oob         <= 1'b0;
            r_instr_hold  <= DATA_W'(NOP);
            r_last_addr   <= '0;
        end else begin
            r_fetch_valid <= fetch_gnt;
            r_oob         <= fetch_gnt && !w_in_range;
            r_instr_hold  <= fetch_instr;
            r_last_addr   <= mem_addr;
        end
    end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Self-checking bench for imem_fetch_arbiter: vector tables for load sequences
// plus hand-written sequences for fetch latency, starvation and patching.
module tb_imem_fetch_arbiter;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_gnt;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        ld_valid;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        core_hold;
    logic [4:0]  load_count;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        r;
        logic        fReq;
        logic [31:0] pc;
        logic        ldV;
        logic [3:0]  ldA;
        logic [31:0] ldD;
        logic        ldL;
        logic        eGnt;
        logic        eRdy;
        logic        eHold;
        logic        eWe;
        logic [4:0]  eCnt;
    } vec_t;

    vec_t tbl[$];

    imem_fetch_arbiter #(.ADDR_W(4), .DATA_W(32), .STARVE_LIM(4)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .core_hold(core_hold), .load_count(load_count),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    imem_ram #(.ADDR_W(4), .DATA_W(32)) ram (
        .i_clk(clk), .i_we(mem_we), .i_addr(mem_addr), .i_wdata(mem_wdata), .o_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] bootWord(input int i);
        return 32'hA500_0011 + 32'(i) * 32'h0001_0101;
    endfunction

    function automatic logic [31:0] eWord(input int i);
        return 32'hE000_0001 + 32'(i);
    endfunction

    function automatic logic [31:0] fWord(input int i);
        return 32'hF000_0001 + 32'(i);
    endfunction

    function automatic vec_t mk(input logic r, input logic fReq, input logic [31:0] pc,
                                input logic ldV, input logic [3:0] ldA, input logic [31:0] ldD,
                                input logic ldL, input logic eGnt, input logic eRdy,
                                input logic eHold, input logic eWe, input logic [4:0] eCnt);
        vec_t v;
        v.r = r; v.fReq = fReq; v.pc = pc; v.ldV = ldV; v.ldA = ldA; v.ldD = ldD; v.ldL = ldL;
        v.eGnt = eGnt; v.eRdy = eRdy; v.eHold = eHold; v.eWe = eWe; v.eCnt = eCnt;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst       = v.r;
        fetch_req = v.fReq;
        fetch_pc  = v.pc;
        ld_valid  = v.ldV;
        ld_addr   = v.ldA;
        ld_data   = v.ldD;
        ld_last   = v.ldL;
    endtask

    task automatic setIn(input logic r, input logic fReq, input logic [31:0] pc,
                         input logic ldV, input logic [3:0] ldA, input logic [31:0] ldD);
        applyStimulus(mk(r, fReq, pc, ldV, ldA, ldD, 1'b0, 0, 0, 0, 0, 0));
    endtask

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive at the start of a cycle, sample at the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            @(negedge clk);
            checkOutput($sformatf("%s[%0d].gnt", tag, i), fetch_gnt, tbl[i].eGnt);
            checkOutput($sformatf("%s[%0d].rdy", tag, i), ld_ready, tbl[i].eRdy);
            checkOutput($sformatf("%s[%0d].hold", tag, i), core_hold, tbl[i].eHold);
            checkOutput($sformatf("%s[%0d].we", tag, i), mem_we, tbl[i].eWe);
            checkOutput($sformatf("%s[%0d].cnt", tag, i), load_count, tbl[i].eCnt);
            cyc();
        end
        tbl.delete();
    endtask

    initial begin
        setIn(1, 0, 0, 0, 0, 0);
        cyc();
        setIn(1, 1, 0, 1, 0, 32'h1111_1111);
        @(negedge clk);
        checkOutput("rst.rdy", ld_ready, 0);
        checkOutput("rst.gnt", fetch_gnt, 0);
        checkOutput("rst.we", mem_we, 0);
        checkOutput("rst.hold", core_hold, 1);
        checkOutput("rst.valid", fetch_valid, 0);
        checkOutput("rst.instr", fetch_instr, 0);
        checkOutput("rst.cnt", load_count, 0);
        cyc();

        // Boot load of words 0..11 with a two-cycle gap after word 3.
        for (int w = 0; w < 4; w++)
            tbl.push_back(mk(0, 1, 0, 1, 4'(w), bootWord(w), 0, 0, 1, 1, 1, 5'(w)));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'd4));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 1, 0, 5'd4));
        for (int w = 4; w < 12; w++)
            tbl.push_back(mk(0, 1, 0, 1, 4'(w), bootWord(w), (w == 11), 0, 1, 1, 1, 5'(w)));
        runTable("boot");

        for (int i = 0; i < 12; i++) begin
            setIn(0, 1, 32'(i * 4), 0, 0, 0);
            @(negedge clk);
            if (i == 0) begin
                checkOutput("run.hold", core_hold, 0);
                checkOutput("run.cnt", load_count, 12);
                checkOutput("run.valid0", fetch_valid, 0);
            end else begin
                checkOutput($sformatf("fetch%0d.valid", i - 1), fetch_valid, 1);
                checkOutput($sformatf("fetch%0d.instr", i - 1), fetch_instr, bootWord(i - 1));
            end
            checkOutput($sformatf("fetch%0d.gnt", i), fetch_gnt, 1);
            checkOutput($sformatf("fetch%0d.addr", i), mem_addr, 32'(i));
            cyc();
        end
        setIn(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("fetch11.valid", fetch_valid, 1);
        checkOutput("fetch11.instr", fetch_instr, bootWord(11));
        checkOutput("idle.rdy", ld_ready, 1);
        cyc();
        @(negedge clk);
        checkOutput("idle.valid", fetch_valid, 0);
        checkOutput("idle.instrHold", fetch_instr, bootWord(11));
        checkOutput("idle.addrHold", mem_addr, 11);
        cyc();

        // Out-of-range fetch: granted, no RAM access, NOP returned.
        setIn(0, 1, 32'h40, 0, 0, 0);
        @(negedge clk);
        checkOutput("oob.gnt", fetch_gnt, 1);
        checkOutput("oob.we", mem_we, 0);
        checkOutput("oob.addr", mem_addr, 11);
        cyc();
        setIn(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("oob.valid", fetch_valid, 1);
        checkOutput("oob.instr", fetch_instr, 0);
        cyc();
        @(negedge clk);
        checkOutput("oob.validFall", fetch_valid, 0);
        cyc();

        // Starvation: four denied loader cycles, then a forced grant.
        for (int c = 1; c <= 5; c++) begin
            setIn(0, 1, 32'h8, 1, 4'd9, 32'h5EED_0009);
            @(negedge clk);
            checkOutput($sformatf("starve%0d.rdy", c), ld_ready, (c == 5));
            checkOutput($sformatf("starve%0d.gnt", c), fetch_gnt, (c != 5));
            checkOutput($sformatf("starve%0d.we", c), mem_we, (c == 5));
            if (c == 2) checkOutput("starve2.instr", fetch_instr, bootWord(2));
            if (c == 5) checkOutput("starve5.addr", mem_addr, 9);
            cyc();
        end
        setIn(0, 1, 32'h8, 1, 4'd10, 32'h0BAD_000A);
        @(negedge clk);
        checkOutput("resume.gnt", fetch_gnt, 1);
        checkOutput("resume.rdyCleared", ld_ready, 0);
        checkOutput("resume.valid", fetch_valid, 0);
        cyc();
        setIn(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("resume.instr", fetch_instr, bootWord(2));
        cyc();

        // Patch write followed immediately by a fetch of the same word.
        setIn(0, 0, 0, 1, 4'd6, 32'hC129_0041);
        @(negedge clk);
        checkOutput("patch.we", mem_we, 1);
        checkOutput("patch.addr", mem_addr, 6);
        checkOutput("patch.wdata", mem_wdata, 32'hC129_0041);
        cyc();
        setIn(0, 1, 32'h18, 0, 0, 0);
        @(negedge clk);
        checkOutput("raw.gnt", fetch_gnt, 1);
        checkOutput("raw.addr", mem_addr, 6);
        cyc();
        setIn(0, 1, 32'h24, 0, 0, 0);
        @(negedge clk);
        checkOutput("raw.instr", fetch_instr, 32'hC129_0041);
        cyc();
        setIn(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("forced.instr", fetch_instr, 32'h5EED_0009);
        cyc();

        // Reset from RUN, partial load, reset mid-load, then a gapped 3-word load.
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd12));
        for (int w = 0; w < 5; w++)
            tbl.push_back(mk(0, 0, 0, 1, 4'(w), eWord(w), 0, 0, 1, 1, 1, 5'(w)));
        tbl.push_back(mk(1, 0, 0, 1, 4'd5, 32'hBAD0_0005, 0, 0, 0, 1, 0, 5'd5));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'd0));
        tbl.push_back(mk(0, 0, 0, 1, 4'd0, fWord(0), 0, 0, 1, 1, 1, 5'd0));
        tbl.push_back(mk(0, 0, 0, 1, 4'd1, fWord(1), 0, 0, 1, 1, 1, 5'd1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 5'd2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'd2));
        tbl.push_back(mk(0, 0, 0, 1, 4'd2, fWord(2), 1, 0, 1, 1, 1, 5'd2));
        runTable("reload");

        setIn(0, 1, 32'h0C, 0, 0, 0);
        @(negedge clk);
        checkOutput("reload.hold", core_hold, 0);
        checkOutput("reload.cnt", load_count, 3);
        checkOutput("reload.gnt", fetch_gnt, 1);
        cyc();
        setIn(0, 1, 32'h10, 0, 0, 0);
        @(negedge clk);
        checkOutput("keep3.instr", fetch_instr, eWord(3));
        cyc();
        setIn(0, 1, 32'h00, 0, 0, 0);
        @(negedge clk);
        checkOutput("keep4.instr", fetch_instr, eWord(4));
        cyc();
        setIn(0, 1, 32'h14, 0, 0, 0);
        @(negedge clk);
        checkOutput("new0.instr", fetch_instr, fWord(0));
        cyc();
        setIn(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("keep5.instr", fetch_instr, bootWord(5));
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
